// File: rtl/time_set_rx_if.sv
// Signal bundle between the UART time-set receiver and the clock core it loads.
// master = receiver side (drives the digits and strobes), slave = consumer side.
interface time_set_rx_if;
    logic       RX;
    logic [3:0] set_hours2;
    logic [3:0] set_hours1;
    logic [3:0] set_mins2;
    logic [3:0] set_mins1;
    logic [3:0] set_secs2;
    logic [3:0] set_secs1;
    logic       set_load;
    logic       rx_error;
    logic       busy;

    modport master (
        input  RX,
        output set_hours2, set_hours1, set_mins2, set_mins1, set_secs2, set_secs1,
        output set_load, rx_error, busy
    );

    modport slave (
        output RX,
        input  set_hours2, set_hours1, set_mins2, set_mins1, set_secs2, set_secs1,
        input  set_load, rx_error, busy
    );
endinterface

// File: rtl/time_set_rx.sv
// UART 8N1 receiver plus "Thhmmss\r" command parser that loads a BCD time.
// Optional inter-byte timeout enabled by defining TIME_SET_TIMEOUT_EN.
module time_set_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT_CLKS = 10000000
) (
    input  logic          CLK100MHZ,
    input  logic          Reset,
    time_set_rx_if.master bus
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [1:0] {P_IDLE, P_DIGIT, P_END} parse_state_t;

    uart_state_t      ustate;
    parse_state_t     pstate;
    logic             rx_meta;
    logic             rx_sync;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [2:0]       didx;
    logic [5:0][3:0]  dig;

    logic stop_sample;
    logic byte_valid;
    logic is_digit;
    logic is_cr;
    logic time_ok;

    // Stop bit is judged combinationally so the load lands one cycle after the sample.
    assign stop_sample = (ustate == U_STOP) && (cnt == BIT_LAST);
    assign byte_valid  = stop_sample && rx_sync;
    assign is_digit    = (shreg >= 8'h30) && (shreg <= 8'h39);
    assign is_cr       = (shreg == 8'h0D);
    assign time_ok     = ((dig[0] < 4'd2) || ((dig[0] == 4'd2) && (dig[1] <= 4'd3)))
                         && (dig[2] <= 4'd5) && (dig[4] <= 4'd5);

    assign bus.busy = (ustate != U_IDLE) || (pstate != P_IDLE);

`ifdef TIME_SET_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
    logic [TO_W-1:0] to_cnt;
`else
    // Timeout is compiled out; keep the parameter referenced for a clean elaboration.
    if (TIMEOUT_CLKS == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (!Reset) begin
            ustate         <= U_IDLE;
            pstate         <= P_IDLE;
            rx_meta        <= 1'b1;
            rx_sync        <= 1'b1;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            didx           <= '0;
            dig            <= '0;
            bus.set_hours2 <= '0;
            bus.set_hours1 <= '0;
            bus.set_mins2  <= '0;
            bus.set_mins1  <= '0;
            bus.set_secs2  <= '0;
            bus.set_secs1  <= '0;
            bus.set_load   <= 1'b0;
            bus.rx_error   <= 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
            to_cnt         <= '0;
`endif
        end else begin
            rx_meta      <= bus.RX;
            rx_sync      <= rx_meta;
            bus.set_load <= 1'b0;
            bus.rx_error <= 1'b0;

            case (ustate)
                U_IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) ustate <= U_START;
                end
                U_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        ustate  <= rx_sync ? U_IDLE : U_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) ustate <= U_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                U_STOP: begin
                    if (stop_sample) begin
                        cnt    <= '0;
                        ustate <= U_IDLE;
                        if (!rx_sync) begin
                            bus.rx_error <= 1'b1;
                            pstate       <= P_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ustate <= U_IDLE;
            endcase

            if (byte_valid) begin
                case (pstate)
                    P_IDLE: begin
                        if (shreg == 8'h54 || shreg == 8'h74) begin
                            pstate <= P_DIGIT;
                            didx   <= '0;
                        end
                    end
                    P_DIGIT: begin
                        if (is_digit) begin
                            dig[didx] <= shreg[3:0];
                            if (didx == 3'd5) pstate <= P_END;
                            else              didx   <= didx + 1'b1;
                        end else begin
                            bus.rx_error <= 1'b1;
                            pstate       <= P_IDLE;
                        end
                    end
                    P_END: begin
                        pstate <= P_IDLE;
                        if (is_cr && time_ok) begin
                            bus.set_hours2 <= dig[0];
                            bus.set_hours1 <= dig[1];
                            bus.set_mins2  <= dig[2];
                            bus.set_mins1  <= dig[3];
                            bus.set_secs2  <= dig[4];
                            bus.set_secs1  <= dig[5];
                            bus.set_load   <= 1'b1;
                        end else begin
                            bus.rx_error <= 1'b1;
                        end
                    end
                    default: pstate <= P_IDLE;
                endcase
            end

`ifdef TIME_SET_TIMEOUT_EN
            // Counts only line-idle gaps inside a command.
            if (pstate == P_IDLE || byte_valid) begin
                to_cnt <= '0;
            end else if (ustate == U_IDLE) begin
                if (to_cnt == TO_LAST) begin
                    to_cnt       <= '0;
                    bus.rx_error <= 1'b1;
                    pstate       <= P_IDLE;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_time_set_rx.sv
// Self-checking bench for time_set_rx: command table plus hand-written corner sequences.
module tb_time_set_rx;

    localparam int unsigned C  = 16;
    localparam int unsigned TO = 2000;

    logic clk;
    logic rst_n;
    time_set_rx_if bus ();

    time_set_rx #(
        .CLKS_PER_BIT (C),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .CLK100MHZ (clk),
        .Reset     (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        logic [23:0] digits;
    } ev_t;

    typedef struct {
        string       cmd;
        bit          cr;
        int          kind;   // 0 none, 1 load, 2 error
        logic [23:0] digits;
    } vec_t;

    ev_t         sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    bit          in_reset = 1'b0;
    logic [23:0] model_digits = '0;
    logic [23:0] prev_d = '0;

    function automatic logic [23:0] cur_digits();
        return {bus.set_hours2, bus.set_hours1, bus.set_mins2, bus.set_mins1,
                bus.set_secs2, bus.set_secs1};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Scoreboard consumer: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        logic [23:0] d;
        ev_t e;
        d = cur_digits();
        if (bus.set_load && bus.rx_error) check("load_and_error_together", 1, 0);
        if (bus.set_load || bus.rx_error) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_event: set_load=%0b rx_error=%0b, none expected",
                         bus.set_load, bus.rx_error);
            end else begin
                e = sb.pop_front();
                check("event_kind_is_load", {31'd0, bus.set_load}, {31'd0, e.is_load});
                if (e.is_load) check("load_digits", {8'd0, d}, {8'd0, e.digits});
            end
        end
        if (!in_reset && d !== prev_d) check("digits_change_only_on_load", {31'd0, bus.set_load}, 1);
        prev_d = d;
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        bus.RX = 1'b0;
        repeat (C) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.RX = b[i];
            repeat (C) @(posedge clk);
        end
        bus.RX = stop_ok;
        repeat (C) @(posedge clk);
        bus.RX = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic expect_ev(input bit is_load, input logic [23:0] digits);
        ev_t e;
        e.is_load = is_load;
        e.digits  = digits;
        sb.push_back(e);
        if (is_load) model_digits = digits;
    endtask

    task automatic settle_and_check(input string tag, input bit exp_busy);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check({tag, "_events_drained"}, sb.size(), 0);
        check({tag, "_digits"}, {8'd0, cur_digits()}, {8'd0, model_digits});
        check({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, exp_busy});
        sb.delete();
    endtask

    task automatic do_reset(input int cycles);
        in_reset = 1'b1;
        rst_n    = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("reset_digits", {8'd0, cur_digits()}, 0);
        check("reset_set_load", {31'd0, bus.set_load}, 0);
        check("reset_rx_error", {31'd0, bus.rx_error}, 0);
        check("reset_busy", {31'd0, bus.busy}, 0);
        bus.RX = 1'b1;
        rst_n  = 1'b1;
        model_digits = '0;
        repeat (5) @(posedge clk);
        in_reset = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"T123456",  1'b1, 1, 24'h123456};
        vecs[1]  = '{"T235959",  1'b1, 1, 24'h235959};
        vecs[2]  = '{"T240000",  1'b1, 2, 24'h0};
        vecs[3]  = '{"xyzT0A",   1'b1, 2, 24'h0};
        vecs[4]  = '{"t000000",  1'b1, 1, 24'h000000};
        vecs[5]  = '{"T196059",  1'b1, 2, 24'h0};
        vecs[6]  = '{"T095960",  1'b1, 2, 24'h0};
        vecs[7]  = '{"T290000",  1'b1, 2, 24'h0};
        vecs[8]  = '{"T2359590", 1'b1, 2, 24'h0};
        vecs[9]  = '{"T12345",   1'b1, 2, 24'h0};
        vecs[10] = '{"abc",      1'b1, 0, 24'h0};
        vecs[11] = '{"T195858",  1'b1, 1, 24'h195858};

        bus.RX = 1'b1;
        rst_n  = 1'b1;
        repeat (2) @(posedge clk);
        do_reset(4);

        for (int v = 0; v < 12; v++) begin
            if (vecs[v].kind == 1)      expect_ev(1'b1, vecs[v].digits);
            else if (vecs[v].kind == 2) expect_ev(1'b0, 24'h0);
            send_str(vecs[v].cmd);
            if (vecs[v].cr) send_byte(8'h0D, 1'b1);
            settle_and_check($sformatf("vec%0d", v), 1'b0);
        end

        // Framing error mid-command, then a good all-zero command.
        expect_ev(1'b0, 24'h0);
        send_str("T1");
        send_byte("2", 1'b0);
        bus.RX = 1'b1;
        repeat (12 * C) @(posedge clk);
        settle_and_check("framing", 1'b0);
        expect_ev(1'b1, 24'h000000);
        send_str("T000000");
        send_byte(8'h0D, 1'b1);
        settle_and_check("after_framing", 1'b0);

        // Load something non-zero so the reset check below is meaningful.
        expect_ev(1'b1, 24'h214233);
        send_str("T214233");
        send_byte(8'h0D, 1'b1);
        settle_and_check("preload", 1'b0);

        // Short low glitch on the line: no byte, no error.
        bus.RX = 1'b0;
        repeat (C / 4) @(posedge clk);
        bus.RX = 1'b1;
        settle_and_check("glitch", 1'b0);

        // Reset in the middle of "T12" and a following frame.
        send_str("T12");
        bus.RX = 1'b0;
        repeat (40) @(posedge clk);
        do_reset(3);
        settle_and_check("mid_reset", 1'b0);

        // Partial command left idle.
        send_str("T12");
`ifdef TIME_SET_TIMEOUT_EN
        expect_ev(1'b0, 24'h0);
        repeat (TO + 10) @(posedge clk);
        settle_and_check("timeout", 1'b0);
`else
        repeat (TO + 10) @(posedge clk);
        settle_and_check("no_timeout", 1'b1);
        do_reset(3);
`endif

        expect_ev(1'b1, 24'h000102);
        send_str("T000102");
        send_byte(8'h0D, 1'b1);
        settle_and_check("final", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/time_set_rx.md
TIME_SET_RX -- requirements
Module: time_set_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (115200 baud at 100 MHz).
REQ-002 Parameter TIMEOUT_CLKS, default 10000000, maximum idle cycles between bytes within one command (used only under REQ-030).
REQ-003 CLK100MHZ  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 RX  input  1  asynchronous UART 8N1 serial line, idle high.
REQ-006 set_hours2, set_hours1, set_mins2, set_mins1, set_secs2, set_secs1  output  4 each  BCD digits of the last accepted time (tens, units).
REQ-007 set_load  output  1  one-cycle strobe: digit outputs hold a new valid time.
REQ-008 rx_error  output  1  one-cycle strobe: framing, syntax, range or timeout error.
REQ-009 busy  output  1  high while a UART frame or command is in progress.

Function
REQ-010 RX SHALL pass through a two-flop synchronizer before any use.
REQ-011 UART FSM states: U_IDLE, U_START, U_DATA, U_STOP.
REQ-012 U_IDLE -> U_START on synchronized RX low; start bit sampled CLKS_PER_BIT/2 cycles later; if high -> U_IDLE with no error (glitch).
REQ-013 Eight data bits SHALL be sampled LSB first, each CLKS_PER_BIT cycles after the previous sample.
REQ-014 Stop sample high -> one-cycle internal byte_valid; stop sample low -> rx_error pulse, byte discarded, parser -> P_IDLE.
REQ-015 Parser FSM states: P_IDLE, P_DIGIT (index 0..5), P_END.
REQ-016 P_IDLE: byte 'T' (0x54) or 't' (0x74) -> P_DIGIT index 0; any other byte ignored, no error.
REQ-017 P_DIGIT: byte 0x30..0x39 stored as BCD (byte minus 0x30) in order H2,H1,M2,M1,S2,S1; after index 5 -> P_END; any other byte -> rx_error, P_IDLE.
REQ-018 P_END: byte 0x0D -> range check; any other byte -> rx_error, P_IDLE.
REQ-019 Range check: valid iff hours 00..23, minutes 00..59, seconds 00..59; a tens digit alone in range does not suffice (e.g. 24, 29 invalid).
REQ-020 Valid: digit outputs updated and set_load high exactly one cycle after the CR stop-bit sample cycle; parser -> P_IDLE.
REQ-021 Invalid: rx_error pulse at the same latency; digit outputs unchanged; parser -> P_IDLE.
REQ-022 Digit outputs SHALL change only on the set_load cycle; set_load and rx_error SHALL never be high together.
REQ-023 busy = (UART FSM not U_IDLE) OR (parser FSM not P_IDLE).
REQ-024 A new start bit arriving during U_STOP evaluation SHALL be detected in the following cycle; back-to-back frames SHALL not be lost.

Reset
REQ-025 While Reset is low on a clock edge: both FSMs idle, synchronizer flops = 1, all digit outputs = 0, set_load = 0, rx_error = 0, busy = 0, counters = 0.
REQ-026 Reset asserted mid-frame or mid-command SHALL abandon it with no set_load and no rx_error pulse.

Configuration
REQ-030 Macro TIME_SET_TIMEOUT_EN defined: an inter-byte counter runs while parser is not P_IDLE and UART is U_IDLE; reaching TIMEOUT_CLKS -> rx_error pulse, parser -> P_IDLE; counter clears on each byte_valid.
REQ-031 Macro undefined: no timeout logic; a partial command waits indefinitely.

Verification
REQ-040 Send "T123456\r" at 115200 baud -> single set_load, digits 1,2,3,4,5,6; rx_error never high.
REQ-041 Send "T235959\r" then "T240000\r" -> first loads 2,3,5,9,5,9; second gives rx_error, digits stay 2,3,5,9,5,9.
REQ-042 Send "xyzT0A\r" -> 'x','y','z' ignored; 'A' gives rx_error; no set_load.
REQ-043 Frame with stop bit forced low mid-command, then "T000000\r" -> one rx_error, then set_load with all zeros.
REQ-044 RX low pulse of CLKS_PER_BIT/4 cycles -> no byte, no error, busy returns low; Reset low mid-"T12" -> all outputs 0, no strobes.
REQ-045 With TIME_SET_TIMEOUT_EN: send "T12", idle TIMEOUT_CLKS+10 cycles -> one rx_error, busy low; without macro -> no error, busy stays high.
